// File: rtl/divisor_booth_inv.sv
// Sequential signed divider, the inverse of the Booth multiplier.
// Divides a 2N-bit two's-complement dividend by an N-bit two's-complement
// divisor using restoring shift-subtract on magnitudes (one quotient bit per
// clock), then applies truncating-division sign fix-up.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any operation in flight
//   start     request, sampled only while idle
//   dividend  2N-bit signed dividend, captured on the start edge
//   divisor   N-bit signed divisor, captured on the start edge
//   quot      N-bit signed quotient, held until the next result
//   rem       N-bit signed remainder (sign follows the dividend), held
//   busy      high while an operation is in flight
//   done      one-cycle pulse when quot/rem/dz/ovf are valid
//   dz        divide-by-zero flag, valid with done and held
//   ovf       quotient does not fit in N signed bits; quot/rem forced to 0
module divisor_booth_inv #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [N-1:0]     quot,
    output logic [N-1:0]     rem,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             ovf
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0]  ONE  = W'(1);
    // 2^(N-1): the largest quotient magnitude a negative result may have.
    localparam logic [W-1:0]  QLIM = ONE << (N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   pr_q, pr_d;        // partial remainder, always < |divisor|
    logic [W-1:0]   a_q, a_d;          // dividend magnitude, becomes quotient magnitude
    logic [N-1:0]   dmag_q, dmag_d;    // |divisor|, up to 2^(N-1) unsigned
    logic           qsign_q, qsign_d;
    logic           rsign_q, rsign_d;
    logic           dzsel_q, dzsel_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;

    logic [N:0]     shifted;
    logic           keep;
    logic           qovf;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        a_d     = a_q;
        dmag_d  = dmag_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dzsel_d = dzsel_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        shifted = {pr_q, a_q[W-1]};
        keep    = (shifted >= {1'b0, dmag_q});
        // A negative quotient may reach -2^(N-1); a positive one only 2^(N-1)-1.
        qovf    = qsign_q ? (a_q > QLIM) : (a_q >= QLIM);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    pr_d    = '0;
                    qsign_d = dividend[W-1] ^ divisor[N-1];
                    rsign_d = dividend[W-1];
                    // Negating the most negative value yields the same bit
                    // pattern, which read as unsigned is the correct magnitude.
                    a_d     = dividend[W-1] ? (~dividend + 1'b1) : dividend;
                    dmag_d  = divisor[N-1] ? (~divisor + 1'b1) : divisor;
                    if (divisor == '0) begin
                        dzsel_d = 1'b1;
                        state_d = StFix;
                    end else begin
                        dzsel_d = 1'b0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                pr_d  = keep ? N'(shifted - {1'b0, dmag_q}) : shifted[N-1:0];
                a_d   = {a_q[W-2:0], keep};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
                if (dzsel_q) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dz_d   = 1'b1;
                    ovf_d  = 1'b0;
                end else if (qovf) begin
                    quot_d = '0;
                    rem_d  = '0;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b1;
                end else begin
                    // Low N bits of a negation depend only on the low N bits.
                    quot_d = qsign_q ? (~a_q[N-1:0] + 1'b1) : a_q[N-1:0];
                    rem_d  = rsign_q ? (~pr_q + 1'b1) : pr_q;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pr_q    <= '0;
            a_q     <= '0;
            dmag_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dzsel_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            a_q     <= a_d;
            dmag_q  <= dmag_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dzsel_q <= dzsel_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_divisor_booth_inv.sv
module tb_divisor_booth_inv;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quot, rem;
    logic         busy, done, dz, ovf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
        time          t;     // negedge time at which done must be seen
        logic [W-1:0] a;
        logic [N-1:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    divisor_booth_inv #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer truncating division. t0 is the negedge at
    // which start/operands were applied; the capture edge follows 5 later.
    function automatic exp_t model(input logic [W-1:0] a, input logic [N-1:0] b, input time t0);
        exp_t e;
        int sa, sd, q, r;
        sa = $signed(a);
        sd = $signed(b);
        e.a = a; e.b = b;
        e.q = '0; e.r = '0; e.dz = 1'b0; e.ovf = 1'b0;
        if (sd == 0) begin
            e.dz = 1'b1;
            e.t  = t0 + 20;
        end else begin
            q = sa / sd;
            r = sa % sd;
            e.t = t0 + 10 * (W + 2);
            if (q < -(1 << (N - 1)) || q > (1 << (N - 1)) - 1) begin
                e.ovf = 1'b1;
            end else begin
                e.q = q[N-1:0];
                e.r = r[N-1:0];
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done=1 quot=%h rem=%h, required no result", quot, rem);
            end else begin
                mon_e = sb.pop_front();
                if (quot !== mon_e.q || rem !== mon_e.r || dz !== mon_e.dz || ovf !== mon_e.ovf
                    || busy !== 1'b0 || $time != mon_e.t) begin
                    fails++;
                    $display("FAIL result %h/%h: got q=%h r=%h dz=%b ovf=%b busy=%b t=%0t, required q=%h r=%h dz=%b ovf=%b busy=0 t=%0t",
                             mon_e.a, mon_e.b, quot, rem, dz, ovf, busy, $time,
                             mon_e.q, mon_e.r, mon_e.dz, mon_e.ovf, mon_e.t);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, $time));
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = N'($urandom);
        if (b != '0) check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [N-1:0] b;
    } op_t;

    op_t dir_ops[$] = '{
        '{8'd21, 4'd3}, '{8'hEB, 4'd3}, '{8'd22, 4'hD}, '{8'hF9, 4'd2},
        '{8'hC0, 4'h8}, '{8'd56, 4'h8}, '{8'h80, 4'hF}, '{8'd50, 4'd0},
        '{8'd9, 4'd2},  '{8'd100, 4'd3}, '{8'h80, 4'h8}, '{8'h7F, 4'h1}
    };
    op_t held_ops[$] = '{
        '{8'd9, 4'd2}, '{8'd50, 4'd0}, '{8'hEB, 4'd3}, '{8'd100, 4'd3}
    };

    initial begin
        logic got;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_quot", {28'b0, quot}, 32'd0);
        check("rst_rem",  {28'b0, rem},  32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dz",   {31'b0, dz},   32'd0);
        check("rst_ovf",  {31'b0, ovf},  32'd0);
        rst = 1'b0;

        // Directed cases, including boundaries, dz and overflow
        foreach (dir_ops[i]) begin
            issue(dir_ops[i].a, dir_ops[i].b);
            drain();
        end

        // start pulsed at E4 with other operands is ignored
        @(negedge clk);
        dividend = 8'd21; divisor = 4'd3; start = 1'b1;
        sb.push_back(model(8'd21, 4'd3, $time));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'd100; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Mid-operation reset at E5 aborts without done
        issue(8'hF9, 4'd2);
        drain();
        @(negedge clk);
        dividend = 8'hEB; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_quot", {28'b0, quot}, 32'd0);
        check("abort_rem",  {28'b0, rem},  32'd0);
        check("abort_dz",   {31'b0, dz},   32'd0);
        check("abort_ovf",  {31'b0, ovf},  32'd0);
        rst = 1'b0;
        issue(8'd9, 4'd2);
        drain();

        // start held high: each op begins on the edge after done
        @(negedge clk);
        dividend = 8'd22; divisor = 4'hD; start = 1'b1;
        sb.push_back(model(8'd22, 4'hD, $time));
        for (int k = 0; k <= held_ops.size(); k++) begin
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL held_done_timeout: got no done in 40 cycles, required done");
                break;
            end
            if (k < held_ops.size()) begin
                dividend = held_ops[k].a;
                divisor  = held_ops[k].b;
                sb.push_back(model(held_ops[k].a, held_ops[k].b, $time));
            end
        end
        start = 1'b0;
        drain();

        // Randomised operands
        repeat (60) begin
            logic [W-1:0] a;
            logic [N-1:0] b;
            if ($urandom_range(0, 1) == 0) a = W'($urandom);
            else a = W'(int'($urandom_range(0, 60)) - 30);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            issue(a, b);
            drain();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
